// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the systolic sequencer and its array bench.
// Holds the default array geometry, the state encoding of the sequencer,
// and the lane/element packing index helpers used on both sides.
package systolic_seq_ctrl_pkg;

  localparam int DIMENSION_DEF = 4;
  localparam int I_BITS_DEF    = 8;
  localparam int O_BITS_DEF    = (2 * I_BITS_DEF) + $clog2(DIMENSION_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // LSB of lane q in a packed lane bus of w-bit elements.
  function automatic int lane_lsb(input int q, input int w);
    return q * w;
  endfunction

  // LSB of result element (i,j) in a packed N*N result bus of w-bit elements.
  function automatic int elem_lsb(input int i, input int j, input int n, input int w);
    return ((i * n) + j) * w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Bundle of host-side and array-side signals of the systolic sequencer.
// Signal names are written from the sequencer's point of view (i_ = into
// the sequencer, o_ = out of it).
//   slave  : the sequencer itself
//   master : host plus array (drives writes/start/ready and the array result)
interface systolic_seq_ctrl_if #(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int O_BITS    = (2 * I_BITS) + $clog2(DIMENSION)
);
  localparam int ROW_W  = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int LANE_W = I_BITS * DIMENSION;
  localparam int C_W    = DIMENSION * DIMENSION * O_BITS;

  logic              i_wr_en;
  logic              i_wr_sel;
  logic [ROW_W-1:0]  i_wr_row;
  logic [LANE_W-1:0] i_wr_data;
  logic              i_start;
  logic              o_busy;
  logic              o_arr_reset;
  logic [LANE_W-1:0] o_a_full;
  logic [LANE_W-1:0] o_b_full;
  logic [C_W-1:0]    i_c_full;
  logic [C_W-1:0]    o_c_full;
  logic              o_valid;
  logic              i_ready;

  modport slave (
    input  i_wr_en, i_wr_sel, i_wr_row, i_wr_data, i_start, i_c_full, i_ready,
    output o_busy, o_arr_reset, o_a_full, o_b_full, o_c_full, o_valid
  );

  modport master (
    output i_wr_en, i_wr_sel, i_wr_row, i_wr_data, i_start, i_c_full, i_ready,
    input  o_busy, o_arr_reset, o_a_full, o_b_full, o_c_full, o_valid
  );

endinterface

// File: rtl/systolic_skew_lane.sv
// One skewed feed lane. Lane LANE at step t carries element (t - LANE) of
// its N-element vector when 0 <= t - LANE < N, otherwise zero.
// Ports:
//   i_step : current feed step t
//   i_vec  : N packed elements, element k at [I_BITS*k +: I_BITS]
//   o_elem : selected element or zero
module systolic_skew_lane
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int DIMENSION = DIMENSION_DEF,
  parameter int I_BITS    = I_BITS_DEF,
  parameter int T_W       = 4,
  parameter int LANE      = 0
) (
  input  logic [T_W-1:0]              i_step,
  input  logic [I_BITS*DIMENSION-1:0] i_vec,
  output logic [I_BITS-1:0]           o_elem
);

  // Constant-index scan keeps every slice in range for any step value.
  always_comb begin
    o_elem = '0;
    for (int k = 0; k < DIMENSION; k++) begin
      if (32'(i_step) == (k + LANE))
        o_elem = i_vec[I_BITS*k +: I_BITS];
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic multiplier.
// Stores operand matrices A and B written row by row by a host, clears the
// array, streams skewed A rows / B columns into the array lanes, waits for
// the pipeline to drain, captures the array result and offers it through a
// valid/ready handshake.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset
//   bus     : systolic_seq_ctrl_if.slave
//     i_wr_en/i_wr_sel/i_wr_row/i_wr_data : operand row write (IDLE only)
//     i_start                             : begin a multiply (IDLE only)
//     o_busy                              : high outside IDLE
//     o_arr_reset                         : array clear (reset or CLEAR)
//     o_a_full/o_b_full                   : skewed lane feeds to the array
//     i_c_full                            : array accumulators
//     o_c_full/o_valid/i_ready            : captured result handshake
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int DIMENSION    = DIMENSION_DEF,
  parameter int I_BITS       = I_BITS_DEF,
  parameter int O_BITS       = (2 * I_BITS) + $clog2(DIMENSION),
  parameter int DRAIN_CYCLES = DIMENSION
) (
  input  logic                i_clock,
  input  logic                i_reset,
  systolic_seq_ctrl_if.slave  bus
);

  localparam int N         = DIMENSION;
  localparam int LANE_W    = I_BITS * N;
  localparam int C_W       = N * N * O_BITS;
  localparam int FEED_LAST = (2 * N) - 2;
  localparam int T_MAX     = max_int((2 * N) - 1, DRAIN_CYCLES);
  localparam int T_W       = $clog2(T_MAX + 1);

  seq_state_e                r_state;
  logic [T_W-1:0]            r_t;
  logic [N-1:0][LANE_W-1:0]  r_a;
  logic [N-1:0][LANE_W-1:0]  r_b;
  logic [LANE_W-1:0]         r_a_full;
  logic [LANE_W-1:0]         r_b_full;
  logic [C_W-1:0]            r_c_full;
  logic                      r_valid;

  logic [T_W-1:0]            w_step;
  logic [N-1:0][LANE_W-1:0]  w_b_col;
  logic [LANE_W-1:0]         w_a_lanes;
  logic [LANE_W-1:0]         w_b_lanes;

  // Lanes are registered, so the skew stage computes the step that will be
  // visible next cycle: step 0 while in CLEAR, t+1 while in FEED.
  assign w_step = (r_state == ST_FEED) ? (r_t + T_W'(1)) : '0;

  // B is stored by rows; lane q needs column q.
  always_comb begin
    w_b_col = '0;
    for (int q = 0; q < N; q++) begin
      for (int k = 0; k < N; k++) begin
        w_b_col[q][I_BITS*k +: I_BITS] = r_b[k][I_BITS*q +: I_BITS];
      end
    end
  end

  for (genvar q = 0; q < N; q++) begin : g_lane
    systolic_skew_lane #(
      .DIMENSION (N),
      .I_BITS    (I_BITS),
      .T_W       (T_W),
      .LANE      (q)
    ) u_a_lane (
      .i_step (w_step),
      .i_vec  (r_a[q]),
      .o_elem (w_a_lanes[I_BITS*q +: I_BITS])
    );

    systolic_skew_lane #(
      .DIMENSION (N),
      .I_BITS    (I_BITS),
      .T_W       (T_W),
      .LANE      (q)
    ) u_b_lane (
      .i_step (w_step),
      .i_vec  (w_b_col[q]),
      .o_elem (w_b_lanes[I_BITS*q +: I_BITS])
    );
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_t      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_full <= '0;
      r_b_full <= '0;
      r_c_full <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_wr_en) begin
            if (bus.i_wr_sel) r_b[bus.i_wr_row] <= bus.i_wr_data;
            else              r_a[bus.i_wr_row] <= bus.i_wr_data;
          end
          if (bus.i_start) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_t      <= '0;
          r_a_full <= w_a_lanes;
          r_b_full <= w_b_lanes;
          r_state  <= ST_FEED;
        end
        ST_FEED: begin
          if (r_t == T_W'(FEED_LAST)) begin
            r_t      <= '0;
            r_a_full <= '0;
            r_b_full <= '0;
            r_state  <= ST_DRAIN;
          end else begin
            r_t      <= r_t + T_W'(1);
            r_a_full <= w_a_lanes;
            r_b_full <= w_b_lanes;
          end
        end
        ST_DRAIN: begin
          if (r_t == T_W'(DRAIN_CYCLES - 1)) begin
            r_c_full <= bus.i_c_full;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_t <= r_t + T_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array clear follows reset combinationally so both sides clear together.
  assign bus.o_arr_reset = i_reset | (r_state == ST_CLEAR);
  assign bus.o_busy      = (r_state != ST_IDLE);
  assign bus.o_a_full    = r_a_full;
  assign bus.o_b_full    = r_b_full;
  assign bus.o_c_full    = r_c_full;
  assign bus.o_valid     = r_valid;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl with a behavioural 4x4 output-stationary array
// attached to the lane outputs.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int IB = 8;
  localparam int OB = 18;
  localparam int LW = IB * N;
  localparam int CW = N * N * OB;

  // Hand-derived lane contents for A = I and B = {1..16} row-major, t = 0..6.
  localparam logic [LW-1:0] EA [7] = '{32'h00000001, 32'h00000000, 32'h00000100,
                                       32'h00000000, 32'h00010000, 32'h00000000,
                                       32'h01000000};
  localparam logic [LW-1:0] EB [7] = '{32'h00000001, 32'h00000205, 32'h00030609,
                                       32'h04070a0d, 32'h080b0e00, 32'h0c0f0000,
                                       32'h10000000};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.DIMENSION(N), .I_BITS(IB), .O_BITS(OB)) bus ();

  systolic_seq_ctrl #(
    .DIMENSION    (N),
    .I_BITS       (IB),
    .O_BITS       (OB),
    .DRAIN_CYCLES (N)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  // Behavioural array: a moves right, b moves down, each PE accumulates.
  int m_a [N][N];
  int m_b [N][N];
  int m_c [N][N];

  always @(posedge clk) begin : array_model
    int ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain = int'(bus.o_a_full[lane_lsb(i, IB) +: IB]);
        else        ain = m_a[i][j-1];
        if (i == 0) bin = int'(bus.o_b_full[lane_lsb(j, IB) +: IB]);
        else        bin = m_b[i-1][j];
        if (bus.o_arr_reset) begin
          m_a[i][j] <= 0;
          m_b[i][j] <= 0;
          m_c[i][j] <= 0;
        end else begin
          m_a[i][j] <= ain;
          m_b[i][j] <= bin;
          m_c[i][j] <= m_c[i][j] + ain * bin;
        end
      end
    end
  end

  always_comb begin
    bus.i_c_full = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.i_c_full[elem_lsb(i, j, N, OB) +: OB] = OB'(m_c[i][j]);
  end

  function automatic logic [CW-1:0] pack_c(input int e [N][N]);
    logic [CW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        v[elem_lsb(i, j, N, OB) +: OB] = OB'(e[i][j]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic sel, input int row, input logic [LW-1:0] data);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_sel  = sel;
    bus.i_wr_row  = 2'(row);
    bus.i_wr_data = data;
    tick();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic load_identity_seq();
    for (int k = 0; k < N; k++) begin
      write_row(1'b0, k, LW'(32'h1 << (8 * k)));
      write_row(1'b1, k, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
    end
  endtask

  // Starts a multiply and returns the cycle (start edge = 0) in which
  // o_valid is first seen, or -1 if it never rises within the budget.
  task automatic start_and_wait(output int lat);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (bus.o_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b expected 0 0", bus.o_busy, bus.o_valid);
    end
    n_checks++;
    if (bus.o_a_full !== '0 || bus.o_b_full !== '0 || bus.o_c_full !== '0) begin
      n_errors++;
      $display("FAIL reset_data: a=%h b=%h c=%h expected all zero", bus.o_a_full, bus.o_b_full, bus.o_c_full);
    end
    n_checks++;
    if (bus.o_arr_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_arr: arr_reset=%b expected 1", bus.o_arr_reset);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.o_arr_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_arr: arr_reset=%b expected 0", bus.o_arr_reset);
    end
  endtask

  task automatic test_identity_lanes();
    int e [N][N];
    int lat;
    load_identity_seq();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    n_checks++;
    if (bus.o_arr_reset !== 1'b1 || bus.o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_cycle: arr_reset=%b busy=%b expected 1 1", bus.o_arr_reset, bus.o_busy);
    end
    for (int t = 0; t < 7; t++) begin
      tick();
      n_checks++;
      if (bus.o_a_full !== EA[t] || bus.o_b_full !== EB[t]) begin
        n_errors++;
        $display("FAIL feed_t%0d: a=%h b=%h expected a=%h b=%h", t, bus.o_a_full, bus.o_b_full, EA[t], EB[t]);
      end
    end
    tick();
    n_checks++;
    if (bus.o_a_full !== '0 || bus.o_b_full !== '0 || bus.o_arr_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_lanes: a=%h b=%h arr_reset=%b expected 0 0 0", bus.o_a_full, bus.o_b_full, bus.o_arr_reset);
    end
    lat = -1;
    for (int n = 10; n <= 40; n++) begin
      tick();
      if (bus.o_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (lat != 13) begin
      n_errors++;
      $display("FAIL identity_latency: first valid cycle %0d expected 13", lat);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = 4 * i + j + 1;
    n_checks++;
    if (bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL identity_c: got %h expected %h", bus.o_c_full, pack_c(e));
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL identity_accept: valid=%b busy=%b expected 0 0", bus.o_valid, bus.o_busy);
    end
  endtask

  task automatic test_max_operands();
    int e [N][N];
    int lat;
    for (int k = 0; k < N; k++) begin
      write_row(1'b0, k, 32'hFFFFFFFF);
      write_row(1'b1, k, 32'hFFFFFFFF);
    end
    start_and_wait(lat);
    n_checks++;
    if (lat != 13) begin
      n_errors++;
      $display("FAIL max_latency: first valid cycle %0d expected 13", lat);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = 260100;
    n_checks++;
    if (bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL max_c: got %h expected %h", bus.o_c_full, pack_c(e));
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int e [N][N];
    int lat;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = 260100;
    start_and_wait(lat);
    n_checks++;
    if (lat != 13) begin
      n_errors++;
      $display("FAIL bp_latency: first valid cycle %0d expected 13", lat);
    end
    for (int c = 0; c < 5; c++) begin
      bus.i_ready   = 1'b0;
      bus.i_start   = 1'b1;
      bus.i_wr_en   = 1'b1;
      bus.i_wr_sel  = 1'b0;
      bus.i_wr_row  = 2'd0;
      bus.i_wr_data = '0;
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_c_full !== pack_c(e)) begin
        n_errors++;
        $display("FAIL bp_hold%0d: valid=%b busy=%b c=%h expected 1 1 %h", c, bus.o_valid, bus.o_busy, bus.o_c_full, pack_c(e));
      end
    end
    bus.i_start = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL bp_release: valid=%b busy=%b c=%h expected 0 0 %h", bus.o_valid, bus.o_busy, bus.o_c_full, pack_c(e));
    end
    // A write accepted while busy would have zeroed C row 0 here.
    start_and_wait(lat);
    n_checks++;
    if (lat != 13 || bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL bp_storage: lat=%0d c=%h expected 13 %h", lat, bus.o_c_full, pack_c(e));
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int e [N][N];
    int lat;
    load_identity_seq();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int t = 0; t <= 3; t++) tick();
    n_checks++;
    if (bus.o_b_full !== EB[3]) begin
      n_errors++;
      $display("FAIL mid_feed_t3: b=%h expected %h", bus.o_b_full, EB[3]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_arr_reset !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_arr_reset: arr_reset=%b expected 1", bus.o_arr_reset);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_a_full !== '0 || bus.o_b_full !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_state: busy=%b valid=%b a=%h b=%h expected 0 0 0 0", bus.o_busy, bus.o_valid, bus.o_a_full, bus.o_b_full);
    end
    load_identity_seq();
    start_and_wait(lat);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = 4 * i + j + 1;
    n_checks++;
    if (lat != 13 || bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL mid_restart: lat=%0d c=%h expected 13 %h", lat, bus.o_c_full, pack_c(e));
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  task automatic test_write_with_start();
    int e [N][N];
    int lat;
    bus.i_wr_en   = 1'b1;
    bus.i_wr_sel  = 1'b0;
    bus.i_wr_row  = 2'd0;
    bus.i_wr_data = 32'h00000002;
    start_and_wait(lat);
    bus.i_wr_en   = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e[i][j] = 4 * i + j + 1;
    e[0] = '{2, 4, 6, 8};
    n_checks++;
    if (lat != 13 || bus.o_c_full !== pack_c(e)) begin
      n_errors++;
      $display("FAIL write_start_c: lat=%0d c=%h expected 13 %h", lat, bus.o_c_full, pack_c(e));
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL write_start_idle: valid=%b busy=%b expected 0 0", bus.o_valid, bus.o_busy);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_sel  = 1'b0;
    bus.i_wr_row  = '0;
    bus.i_wr_data = '0;
    bus.i_start   = 1'b0;
    bus.i_ready   = 1'b0;
    test_reset();
    test_identity_lanes();
    test_max_operands();
    test_backpressure();
    test_reset_midrun();
    test_write_with_start();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the N×N output-stationary systolic multiplier (systolic_processorVCounter). It holds operand matrices A and B written by a host, clears the array accumulators, and streams skewed row/column lanes into i_a_full/i_b_full. After the pipeline drains it captures o_c_full and offers the result through a valid/ready handshake. It replaces file-driven stimulus so the array can run in-system.

Parameters:
DIMENSION, 4, array size N (lanes, rows, columns)
I_BITS, 8, operand element width
O_BITS, (2*I_BITS)+$clog2(DIMENSION), result element width
DRAIN_CYCLES, DIMENSION, cycles waited after last feed before capture (N-1 hops + 1 accumulate)

Ports:
i_clock  in  1  single clock, rising edge
i_reset  in  1  synchronous, active-high
i_wr_en  in  1  operand row write strobe
i_wr_sel  in  1  0 = A, 1 = B
i_wr_row  in  $clog2(N)  row index k
i_wr_data  in  I_BITS*N  element j at [I_BITS*j +: I_BITS] = M[k][j]
i_start  in  1  start a multiply
o_busy  out  1  high in every state except IDLE
o_arr_reset  out  1  to array i_reset
o_a_full  out  I_BITS*N  to array i_a_full, lane q at [I_BITS*q +: I_BITS]
o_b_full  out  I_BITS*N  to array i_b_full, same packing
i_c_full  in  N*N*O_BITS  from array o_c_full
o_c_full  out  N*N*O_BITS  captured result, element i*N+j at [O_BITS*(i*N+j) +: O_BITS]
o_valid  out  1  result available
i_ready  in  1  consumer accepts result

Behaviour:
- Decided: one clock, i_clock; reset i_reset is synchronous and active-high.
- Reset: state=IDLE; A/B storage zeroed; o_a_full=o_b_full=0, o_c_full=0, o_valid=0, o_busy=0. o_arr_reset = i_reset OR (state==CLEAR). It is combinational so the array clears whenever the controller does.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: i_wr_en writes row i_wr_row of the selected matrix at the edge. i_start=1 → CLEAR. A write and a start in the same cycle are both accepted, and the new row is used.
- CLEAR, 1 cycle: o_arr_reset=1, lanes zero, t=0 → FEED.
- FEED, 2N-1 cycles, t=0..2N-2 (registered lanes):
  - A lane q = A[q][t-q], B lane q = B[t-q][q], when 0≤t-q<N; otherwise 0.
  - After t=2N-2 → DRAIN with lanes 0.
- DRAIN, DRAIN_CYCLES cycles with lanes 0. At the last edge, o_c_full ← i_c_full and o_valid ← 1 → DONE.
- DONE:
  - o_valid and o_c_full hold until i_valid&&i_ready is seen at an edge (o_valid=1 && i_ready=1).
  - Then o_valid=0 → IDLE. o_c_full keeps its last value.
- Latency: with start sampled at edge e0, CLEAR is cycle e0+1, FEED is cycles e0+2..e0+2N, DRAIN follows, and o_valid is first high in cycle e0+2N+DRAIN_CYCLES+1. For N=4, D=4 this is cycle 13.
- While busy: i_start and i_wr_en are ignored, and storage is unchanged.
- i_ready while o_valid=0 has no effect. i_ready held high gives a 1-cycle DONE.
- i_reset mid-operation: return to IDLE next edge, outputs to reset values, in-flight result discarded, array cleared via o_arr_reset.
- Counter t is wide enough for max(2N-1, DRAIN_CYCLES) and never wraps within a state.
- No arithmetic here; widths are pass-through.

Decomposition:
- Shared package/header: DIMENSION, I_BITS, O_BITS defaults; state encodings; lane pack/unpack index macros shared with the array bench.
- One sub-module, systolic_skew_lane: given lane index q, step t and the N-element row/column, it outputs the element or zero. Instantiate it 2N times.

Test Plan (N=4, I_BITS=8, DRAIN_CYCLES=4):
1. Write A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, then start. Require o_arr_reset high cycle 1, o_valid first in cycle 13, and C=B.
2. A all 255, B all 255, start. Every C element = 4*65025 = 260100, which fits in O_BITS=18.
3. Check FEED lanes cycle-by-cycle for the scenario-1 data. At t=0 o_a_full = {0,0,0,A[0][0]}; at t=6 only lane 3 is nonzero (A[3][3]); B is checked the same way.
4. Hold i_ready=0 for 5 cycles in DONE. o_valid and o_c_full must stay stable, with i_start and i_wr_en ignored. Raise i_ready → IDLE next edge.
5. Pulse i_reset during FEED t=3. Next cycle must show IDLE, lanes 0, o_valid 0. A restart after rewriting gives the correct C.
6. Issue write and start together in IDLE, changing A row 0 to {2,0,0,0} with B as in scenario 1. C row 0 = {2,4,6,8}.
